// File: rtl/prg_dma_loader_if.sv
// rtl/prg_dma_loader_if.sv - HPS download stream and PET memory write port bundle
// master is the loader side; slave is the HPS/memory side.
interface prg_dma_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic [15:0] dma_addr;
  logic [7:0]  dma_din;
  logic        dma_we;
  logic        dma_ack;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ack,
    output ioctl_wait, dma_addr, dma_din, dma_we
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, dma_ack,
    input  ioctl_wait, dma_addr, dma_din, dma_we
  );
endinterface

// File: rtl/prg_dma_loader.sv
// rtl/prg_dma_loader.sv - PRG/ROM image loader from the HPS download stream into PET memory
// Holds the CPU while a load runs; a PRG load ends by patching the end pointer at 002A/002B.
module prg_dma_loader #(
  parameter logic [7:0]  PRG_INDEX = 8'h41,
  parameter logic [7:0]  ROM_INDEX = 8'h00,
  parameter logic [15:0] RAM_TOP   = 16'h8000
) (
  input  logic             clk,
  input  logic             reset_n,
  prg_dma_loader_if.master bus,
  output logic             cpu_hold,
  output logic             load_done,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_LO, S_HDR_HI, S_DATA, S_ROM, S_PTR_LO, S_PTR_HI, S_DONE
  } state_t;

  state_t      state;
  logic [15:0] load_ptr;
  logic        dl_q;
  logic        dl_rise;
  logic        wr_ack;
  logic        rom_hit;

  assign dl_rise = bus.ioctl_download && !dl_q;
  assign wr_ack  = bus.dma_we && bus.dma_ack;
  assign rom_hit = (bus.ioctl_addr[15:0] >= 16'h0400) && (bus.ioctl_addr[15:0] < 16'h8000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      load_ptr       <= '0;
      // Held high so a download left asserted across reset is not mistaken for a new start.
      dl_q           <= 1'b1;
      bus.ioctl_wait <= 1'b0;
      bus.dma_we     <= 1'b0;
      bus.dma_addr   <= '0;
      bus.dma_din    <= '0;
      cpu_hold       <= 1'b0;
      load_done      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      dl_q      <= bus.ioctl_download;
      load_done <= 1'b0;
      if (wr_ack) begin
        bus.dma_we     <= 1'b0;
        bus.ioctl_wait <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (dl_rise) begin
            if (bus.ioctl_index == PRG_INDEX) begin
              state    <= S_HDR_LO;
              overflow <= 1'b0;
              load_ptr <= '0;
              cpu_hold <= 1'b1;
            end else if (bus.ioctl_index == ROM_INDEX) begin
              state    <= S_ROM;
              cpu_hold <= 1'b1;
            end
          end
        end

        S_HDR_LO: begin
          if (bus.ioctl_wr && bus.ioctl_addr == 25'd0) begin
            load_ptr[7:0] <= bus.ioctl_dout;
            state         <= S_HDR_HI;
          end else if (!bus.ioctl_download) begin
            state     <= S_DONE;
            load_done <= 1'b1;
          end
        end

        S_HDR_HI: begin
          if (bus.ioctl_wr && bus.ioctl_addr == 25'd1) begin
            load_ptr[15:8] <= bus.ioctl_dout;
            state          <= S_DATA;
          end else if (!bus.ioctl_download) begin
            state     <= S_DONE;
            load_done <= 1'b1;
          end
        end

        S_DATA: begin
          if (bus.dma_we) begin
            if (bus.dma_ack) load_ptr <= load_ptr + 16'd1;
          end else if (bus.ioctl_wr) begin
            if (load_ptr < RAM_TOP) begin
              bus.dma_addr   <= load_ptr;
              bus.dma_din    <= bus.ioctl_dout;
              bus.dma_we     <= 1'b1;
              bus.ioctl_wait <= 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end else if (!bus.ioctl_download) begin
            state        <= S_PTR_LO;
            bus.dma_addr <= 16'h002A;
            bus.dma_din  <= load_ptr[7:0];
            bus.dma_we   <= 1'b1;
          end
        end

        S_ROM: begin
          // An in-flight write still completes before the load is closed.
          if (bus.dma_we) begin
          end else if (bus.ioctl_wr) begin
            if (rom_hit) begin
              bus.dma_addr   <= bus.ioctl_addr[15:0] + 16'h8000;
              bus.dma_din    <= bus.ioctl_dout;
              bus.dma_we     <= 1'b1;
              bus.ioctl_wait <= 1'b1;
            end
          end else if (!bus.ioctl_download) begin
            state     <= S_DONE;
            load_done <= 1'b1;
          end
        end

        S_PTR_LO: begin
          if (wr_ack) begin
            state        <= S_PTR_HI;
            bus.dma_addr <= 16'h002B;
            bus.dma_din  <= load_ptr[15:8];
            bus.dma_we   <= 1'b1;
          end
        end

        S_PTR_HI: begin
          if (wr_ack) begin
            state     <= S_DONE;
            load_done <= 1'b1;
          end
        end

        S_DONE: begin
          state    <= S_IDLE;
          cpu_hold <= 1'b0;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prg_dma_loader.sv
// tb/tb_prg_dma_loader.sv - directed table-driven bench for prg_dma_loader
// A negedge process drives dma_ack with a per-load delay and records accepted writes.
module tb_prg_dma_loader;

  logic clk;
  logic reset_n;
  logic cpu_hold;
  logic load_done;
  logic overflow;

  prg_dma_loader_if bus ();

  prg_dma_loader #(
    .PRG_INDEX(8'h41),
    .ROM_INDEX(8'h00),
    .RAM_TOP  (16'h8000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .load_done(load_done),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  index;
    logic [24:0] base;
    logic [3:0]  nbytes;
    logic [47:0] bytes;
    logic [7:0]  ack_dly;
    logic [2:0]  nwr;
    logic [95:0] wr;
    logic        done;
    logic        ovf;
    logic [3:0]  wait_max;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  int          ack_dly = 0;
  int          wcnt    = 0;
  logic [15:0] wq_addr [$];
  logic [7:0]  wq_data [$];
  int          wait_runs [$];
  int          wait_cur  = 0;
  int          n_done    = 0;
  int          stab_err  = 0;
  logic        prev_pend = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_din  = '0;

  // Ack is updated first so the recorded write matches what the next posedge accepts.
  always @(negedge clk) begin
    if (ack_dly == 0) begin
      bus.dma_ack = 1'b1;
    end else if (bus.dma_we && wcnt == ack_dly) begin
      bus.dma_ack = 1'b1;
      wcnt = 0;
    end else begin
      bus.dma_ack = 1'b0;
      if (bus.dma_we) wcnt = wcnt + 1;
      else wcnt = 0;
    end

    if (bus.dma_we && bus.dma_ack) begin
      wq_addr.push_back(bus.dma_addr);
      wq_data.push_back(bus.dma_din);
    end
    if (load_done) n_done = n_done + 1;
    if (bus.ioctl_wait) begin
      wait_cur = wait_cur + 1;
    end else if (wait_cur > 0) begin
      wait_runs.push_back(wait_cur);
      wait_cur = 0;
    end
    if (reset_n && prev_pend && (bus.dma_addr != prev_addr || bus.dma_din != prev_din))
      stab_err = stab_err + 1;
    prev_pend = bus.dma_we && !bus.dma_ack;
    prev_addr = bus.dma_addr;
    prev_din  = bus.dma_din;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int n = 0;
    while (bus.ioctl_wait && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check("wait_release", 32'(bus.ioctl_wait), 32'd0);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk);
    bus.ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int qbase = wq_addr.size();
    int wbase = wait_runs.size();
    int dbase = n_done;
    int sbase = stab_err;
    int n = 0;
    int wmax = 0;
    logic [23:0] got;
    ack_dly = int'(v.ack_dly);
    bus.ioctl_index = v.index;
    @(negedge clk);
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    for (int i = 0; i < int'(v.nbytes); i++)
      send_byte(v.base + 25'(i), v.bytes[i*8 +: 8]);
    check($sformatf("v%0d_hold_mid", id), 32'(cpu_hold), 32'(v.done));
    bus.ioctl_download = 1'b0;
    while (n_done == dbase && n < 300) begin
      @(negedge clk);
      n = n + 1;
    end
    repeat (4) @(negedge clk);
    check($sformatf("v%0d_nwr", id), 32'(wq_addr.size() - qbase), 32'(v.nwr));
    for (int k = 0; k < int'(v.nwr); k++) begin
      got = (qbase + k < wq_addr.size()) ? {wq_addr[qbase+k], wq_data[qbase+k]} : 24'h0;
      check($sformatf("v%0d_wr%0d", id, k), 32'(got), 32'(v.wr[k*24 +: 24]));
    end
    for (int k = wbase; k < wait_runs.size(); k++)
      if (wait_runs[k] > wmax) wmax = wait_runs[k];
    check($sformatf("v%0d_done_pulses", id), 32'(n_done - dbase), 32'(v.done));
    check($sformatf("v%0d_overflow", id), 32'(overflow), 32'(v.ovf));
    check($sformatf("v%0d_wait_len", id), 32'(wmax), 32'(v.wait_max));
    check($sformatf("v%0d_stable", id), 32'(stab_err - sbase), 32'd0);
    check($sformatf("v%0d_hold_end", id), 32'(cpu_hold), 32'd0);
  endtask

  initial begin
    int dbase;
    reset_n            = 1'b0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'h00;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = 8'h00;

    vecs[0] = '{index:8'h41, base:25'h0, nbytes:4'd4, bytes:48'h0000_BBAA_0401, ack_dly:8'd0,
                nwr:3'd4, wr:96'h002B04_002A03_0402BB_0401AA, done:1'b1, ovf:1'b0, wait_max:4'd1};
    vecs[1] = '{index:8'h41, base:25'h0, nbytes:4'd4, bytes:48'h0000_BBAA_0401, ack_dly:8'd5,
                nwr:3'd4, wr:96'h002B04_002A03_0402BB_0401AA, done:1'b1, ovf:1'b0, wait_max:4'd6};
    vecs[2] = '{index:8'h41, base:25'h0, nbytes:4'd6, bytes:48'h4433_2211_7FFE, ack_dly:8'd0,
                nwr:3'd4, wr:96'h002B80_002A00_7FFF22_7FFE11, done:1'b1, ovf:1'b1, wait_max:4'd1};
    vecs[3] = '{index:8'h00, base:25'h3FF, nbytes:4'd3, bytes:48'h0000_005C_5B5A, ack_dly:8'd0,
                nwr:3'd2, wr:96'h000000_000000_84015C_84005B, done:1'b1, ovf:1'b1, wait_max:4'd1};
    vecs[4] = '{index:8'h41, base:25'h0, nbytes:4'd1, bytes:48'h0000_0000_0001, ack_dly:8'd0,
                nwr:3'd0, wr:96'h0, done:1'b1, ovf:1'b0, wait_max:4'd0};
    vecs[5] = '{index:8'h55, base:25'h0, nbytes:4'd2, bytes:48'h0000_0000_0401, ack_dly:8'd0,
                nwr:3'd0, wr:96'h0, done:1'b0, ovf:1'b0, wait_max:4'd0};

    #12;
    check("rst_wait",     32'(bus.ioctl_wait), 32'd0);
    check("rst_we",       32'(bus.dma_we),     32'd0);
    check("rst_hold",     32'(cpu_hold),       32'd0);
    check("rst_done",     32'(load_done),      32'd0);
    check("rst_overflow", 32'(overflow),       32'd0);
    check("rst_addr",     32'(bus.dma_addr),   32'd0);
    check("rst_din",      32'(bus.dma_din),    32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Reset while a data write is stalled by a late ack.
    ack_dly = 50;
    dbase = n_done;
    bus.ioctl_index = 8'h41;
    @(negedge clk);
    @(negedge clk);
    bus.ioctl_download = 1'b1;
    @(negedge clk);
    send_byte(25'd0, 8'h00);
    send_byte(25'd1, 8'h10);
    send_byte(25'd2, 8'h77);
    check("mid_we",   32'(bus.dma_we),   32'd1);
    check("mid_addr", 32'(bus.dma_addr), 32'h1000);
    check("mid_din",  32'(bus.dma_din),  32'h77);
    check("mid_wait", 32'(bus.ioctl_wait), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_we",   32'(bus.dma_we),     32'd0);
    check("arst_hold", 32'(cpu_hold),       32'd0);
    check("arst_wait", 32'(bus.ioctl_wait), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus.ioctl_download = 1'b0;
    repeat (10) @(negedge clk);
    check("arst_no_done", 32'(n_done - dbase), 32'd0);
    check("arst_idle_hold", 32'(cpu_hold), 32'd0);

    run_vec(vecs[0], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
